// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } lsu_state_e;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic is_subword(input logic [1:0] size);
    is_subword = (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges store data into the addressed lane(s) of an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] rword,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rword;
    endcase
  end

  // Only the addressed lane(s) of the old word are replaced; word stores pass through.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a combinational-read,
// word-wide memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state, next;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] old_word;
  logic [31:0] rdata;
  logic        abort;
  logic        accept;
  logic        bad_align;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept    = (state == IDLE) && req_i;
  assign bad_align = is_misaligned(size_i, addr_i[1:0]);

  lsu_lane_align u_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .offset      (req_addr[1:0]),
    .rword       (mem_rdata_i),
    .old_word    (old_word),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (bad_align)                     next = DONE;
          else if (!we_i || is_subword(size_i)) next = READ;
          else                               next = WRITE;
        end
      end
      READ:    next = req_we ? WRITE : DONE;
      WRITE:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      req_size     <= SZ_BYTE;
      req_unsigned <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      old_word     <= '0;
      rdata        <= '0;
      abort        <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        req_we       <= we_i;
        req_size     <= size_i;
        req_unsigned <= unsigned_i;
        req_addr     <= addr_i;
        req_wdata    <= wdata_i;
        abort        <= bad_align;
      end
      // A READ either completes a load or captures the word for a merge.
      if (state == READ) begin
        if (req_we) old_word <= mem_rdata_i;
        else        rdata    <= load_data;
      end
    end
  end

  assign ready_o     = (state == IDLE);
  assign done_o      = (state == DONE);
  assign misalign_o  = (state == DONE) && abort;
  assign rdata_o     = rdata;
  assign mem_addr_o  = {req_addr[31:2], 2'b00};
  assign mem_read_o  = (state == READ);
  assign mem_write_o = (state == WRITE);
  assign mem_wdata_o = (state == WRITE) ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses against a small
// word memory, with expected results queued at drive time and popped at done.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = SZ_BYTE;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, misalign, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .unsigned_i  (uns),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .ready_o     (ready),
    .done_o      (done),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .mem_addr_o  (mem_addr),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory; pokes preload it while the unit is idle.
  logic [31:0] mem [0:15];
  logic        poke = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  always @(posedge clk) begin
    if (poke)           mem[poke_idx] <= poke_val;
    else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_addr[5:2]];

  int overlap = 0;
  int bad_addr = 0;
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if ((mem_read || mem_write) && (mem_addr[1:0] != 2'b00 || mem_addr[31:6] != 26'h0)) bad_addr++;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  lat;
    logic [3:0]  reads;
    logic [3:0]  writes;
  } exp_t;

  exp_t sb[$];

  logic [31:0] obs_rdata;
  logic        obs_mis;
  int          obs_lat, obs_reads, obs_writes;

  function automatic exp_t mk(input logic [31:0] r, input logic m, input int l, input int rd, input int wr);
    exp_t e;
    e.rdata  = r;
    e.mis    = m;
    e.lat    = 4'(l);
    e.reads  = 4'(rd);
    e.writes = 4'(wr);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({tag, " ready_timeout"}, {31'h0, ready}, 32'h1);
  endtask

  task automatic set_word(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d, input exp_t e);
    sb.push_back(e);
    wait_ready("access");
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    obs_lat = 15; obs_reads = 0; obs_writes = 0; obs_mis = 1'b0; obs_rdata = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs_reads  += int'(mem_read);
      obs_writes += int'(mem_write);
      if (done) begin
        obs_lat   = k;
        obs_mis   = misalign;
        obs_rdata = rdata;
        break;
      end
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, " latency"},  32'(obs_lat),    32'(e.lat));
    check({tag, " misalign"}, {31'h0, obs_mis}, {31'h0, e.mis});
    check({tag, " rdata"},    obs_rdata,       e.rdata);
    check({tag, " reads"},    32'(obs_reads),  32'(e.reads));
    check({tag, " writes"},   32'(obs_writes), 32'(e.writes));
  endtask

  initial begin
    int sw, sd;
    $display("[TB] start");

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready",     {31'h0, ready},     32'h1);
    check("rst done",      {31'h0, done},      32'h0);
    check("rst misalign",  {31'h0, misalign},  32'h0);
    check("rst mem_read",  {31'h0, mem_read},  32'h0);
    check("rst mem_write", {31'h0, mem_write}, 32'h0);
    check("rst rdata",     rdata,     32'h0);
    check("rst mem_addr",  mem_addr,  32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    set_word(4'd4, 32'h8040_20F0);

    // Loads of every size and extension mode
    apply_stimulus(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, mk(32'hFFFF_FFF0, 1'b0, 2, 1, 0));
    check_output("LB 0x10");
    apply_stimulus(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, mk(32'h0000_0080, 1'b0, 2, 1, 0));
    check_output("LBU 0x13");
    apply_stimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, mk(32'hFFFF_8040, 1'b0, 2, 1, 0));
    check_output("LH 0x12");
    apply_stimulus(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, mk(32'h0000_20F0, 1'b0, 2, 1, 0));
    check_output("LHU 0x10");
    apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, mk(32'h8040_20F0, 1'b0, 2, 1, 0));
    check_output("LW 0x10");

    // Sub-word stores: read-modify-write, rdata untouched
    apply_stimulus(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_56AB, mk(32'h8040_20F0, 1'b0, 3, 1, 1));
    check_output("SB 0x11");
    apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, mk(32'h8040_ABF0, 1'b0, 2, 1, 0));
    check_output("LW after SB");

    set_word(4'd4, 32'h8040_20F0);
    apply_stimulus(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF_1234, mk(32'h8040_ABF0, 1'b0, 3, 1, 1));
    check_output("SH 0x12");
    apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, mk(32'h1234_20F0, 1'b0, 2, 1, 0));
    check_output("LW after SH");

    // Word store goes straight to WRITE
    apply_stimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, mk(32'h1234_20F0, 1'b0, 2, 0, 1));
    check_output("SW 0x10");
    check("mem after SW", mem[4], 32'hDEAD_BEEF);
    apply_stimulus(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, mk(32'hFFFF_FFAD, 1'b0, 2, 1, 0));
    check_output("LB 0x12");

    // Misaligned accesses abort after one cycle with no strobes
    apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, mk(32'hFFFF_FFAD, 1'b1, 1, 0, 0));
    check_output("LW 0x12 misaligned");
    apply_stimulus(1'b1, SZ_HALF, 1'b0, 32'h11, 32'h5555_5555, mk(32'hFFFF_FFAD, 1'b1, 1, 0, 0));
    check_output("SH 0x11 misaligned");
    check("mem after misaligned", mem[4], 32'hDEAD_BEEF);

    // Reset during the READ of a byte store
    set_word(4'd4, 32'h8040_20F0);
    wait_ready("abort");
    req = 1'b1; we = 1'b1; size = SZ_BYTE; uns = 1'b0; addr = 32'h11; wdata = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort in READ", {31'h0, mem_read}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort ready",     {31'h0, ready},     32'h1);
    check("abort mem_write", {31'h0, mem_write}, 32'h0);
    check("abort done",      {31'h0, done},      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sw = 0;
    sd = 0;
    repeat (3) begin
      @(negedge clk);
      sw += int'(mem_write);
      sd += int'(done);
    end
    check("abort later writes", 32'(sw), 32'h0);
    check("abort later done",   32'(sd), 32'h0);
    check("abort mem",          mem[4],  32'h8040_20F0);

    // req held high while busy: the address change during READ is ignored
    set_word(4'd5, 32'h1122_3344);
    wait_ready("hold");
    req = 1'b1; we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h10;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold busy ready", {31'h0, ready}, 32'h0);
    addr = 32'h14;
    @(negedge clk);
    check("hold first done",  {31'h0, done},  32'h1);
    check("hold first rdata", rdata,          32'h8040_20F0);
    check("hold done ready",  {31'h0, ready}, 32'h0);
    @(negedge clk);
    check("hold idle ready", {31'h0, ready}, 32'h1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("hold re-accept read", {31'h0, mem_read}, 32'h1);
    check("hold re-accept addr", mem_addr,          32'h14);
    @(negedge clk);
    check("hold second done",  {31'h0, done}, 32'h1);
    check("hold second rdata", rdata,         32'h1122_3344);

    check("strobe overlap", 32'(overlap),  32'h0);
    check("strobe address", 32'(bad_addr), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
